instr_seq_ctrl: RTL
===================

// Module: instr_seq_ctrl
// PURPOSE
//  Fetch/decode/execute sequencer for the 19-bit CPU. Owns the PC and issues
//  instruction and operand memory reads and writes. Pulses the IR load strobe
//  and waits out the IR's two-register pipeline before it samples OPCODE.
//  It then drives one-cycle execute/branch/halt controls onto the control bus.
// PARAMETERS
//  WORD_SIZE    19  instruction/data word width
//  OPCODE_W      5  opcode field width (IR bits [WORD_SIZE-1 -: 5])
//  ADDR_W       14  address field width (= WORD_SIZE-OPCODE_W)
//  IR_LAT        2  cycles from load strobe until OPCODE/addr valid at IR outputs
//  MEM_TIMEOUT  15  max cycles waiting for mem_ack before the fault trap
// PORTS
//  CLK          in   1        clock, all state on rising edge
//  RST_N        in   1        synchronous active-low reset
//  run          in   1        level; sequencer leaves IDLE/HALT when high
//  mem_req      out  1        memory request; held until mem_ack
//  mem_we       out  1        1 = write (STORE), 0 = read; valid with mem_req
//  mem_addr     out  ADDR_W   request address; stable while mem_req
//  mem_ack      in   1        one-cycle completion; ignored when mem_req low
//  load_reg     out  1        one-cycle load strobe to a register
//  load_select  out  3        target: 0 LOAD_IR, 1 LOAD_ACC, others reserved
//  opcode       in   OPCODE_W from IR
//  ir_addr      in   ADDR_W   address operand from IR
//  acc_zero     in   1        accumulator == 0 flag
//  alu_en       out  1        one-cycle ALU execute strobe
//  alu_op       out  OPCODE_W opcode forwarded to ALU; valid with alu_en
//  pc           out  ADDR_W   program counter
//  halted       out  1        high in HALT state
//  fault        out  1        sticky; set on mem timeout or illegal opcode
// BEHAVIOUR
//  Reset (RST_N low at edge), overriding everything including mid-transaction:
//   state=IDLE, pc=0, all strobes/mem_req/mem_we/halted/fault=0, mem_addr=0.
//  States and transitions (one transition per edge max):
//   IDLE    -> FETCH when run=1.
//   FETCH   mem_req=1, mem_we=0, mem_addr=pc; on mem_ack -> LOAD.
//   LOAD    load_reg=1, load_select=LOAD_IR for exactly 1 cycle; pc<=pc+1
//           (wraps 2^ADDR_W-1 -> 0); -> WAIT_IR.
//   WAIT_IR count IR_LAT cycles, then -> DECODE (OPCODE sampled only here).
//   DECODE  5'h00 NOP -> FETCH; 5'h01 LOAD -> MEM (read ir_addr);
//           5'h02 STORE -> MEM (write ir_addr); 5'h03 JMP pc<=ir_addr -> FETCH;
//           5'h04 JZ pc<=ir_addr if acc_zero -> FETCH; 5'h08..5'h0F ALU -> EXEC;
//           5'h1F HALT -> HALT; any other -> fault=1, -> HALT.
//   MEM     mem_req=1, mem_addr=ir_addr, mem_we=(STORE); on mem_ack:
//           LOAD -> load_reg=1, load_select=LOAD_ACC next cycle, then FETCH;
//           STORE -> FETCH.
//   EXEC    alu_en=1, alu_op=opcode for exactly 1 cycle -> FETCH.
//   HALT    halted=1; stays until reset (run ignored).
//  Timeout: MEM_TIMEOUT consecutive cycles in FETCH/MEM without mem_ack set
//   fault=1, drop mem_req, and -> HALT.
//  mem_req deasserts the cycle after the mem_ack edge; back-to-back fetch
//   re-asserts no earlier than the following FETCH cycle.
//  Branch taken in DECODE overrides the LOAD-stage increment; pc updates once.
//  run falling mid-instruction has no effect; it is only checked in IDLE.
//  Minimum NOP latency: FETCH(1 with immediate ack)+LOAD+2 WAIT+DECODE = 5 cycles.
// TESTING
//  1 reset mid-FETCH (mem_req=1) -> next cycle mem_req=0, pc=0, state IDLE.
//  2 run=1, mem returns NOP (ack 0-wait) x3 -> load_reg/LOAD_IR every 5 cycles, pc 0->3.
//  3 JMP 14'h3FF0 at pc=5 -> next fetch mem_addr=14'h3FF0; pc=14'h3FFF NOP -> wraps to 0.
//  4 JZ 14'h0020 with acc_zero=0 then 1 -> fetch pc+1, then 14'h0020.
//  5 LOAD 14'h0100, ack after 3 cycles -> mem_we=0, one load_select=LOAD_ACC strobe;
//    STORE -> mem_we=1 held until ack.
//  6 no mem_ack for 15 cycles, or opcode 5'h10 -> fault=1, halted=1, mem_req=0; run ignored.

Source files
------------

// File: rtl/instr_seq_ctrl.sv
// Fetch/decode/execute sequencer: owns the PC, issues memory reads/writes and one-cycle control strobes.
// Latency: NOP takes 5 cycles (fetch, load, 2 IR wait, decode); mem_req is held until mem_ack or a 15-cycle timeout.
module instr_seq_ctrl #(
    parameter int WORD_SIZE   = 19,
    parameter int OPCODE_W    = 5,
    parameter int ADDR_W      = WORD_SIZE - OPCODE_W,
    parameter int IR_LAT      = 2,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                run,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic                mem_ack,
    output logic                load_reg,
    output logic [2:0]          load_select,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [ADDR_W-1:0]   ir_addr,
    input  logic                acc_zero,
    output logic                alu_en,
    output logic [OPCODE_W-1:0] alu_op,
    output logic [ADDR_W-1:0]   pc,
    output logic                halted,
    output logic                fault
);

    localparam int TMO_W  = $clog2(MEM_TIMEOUT + 1);
    localparam int WAIT_W = $clog2(IR_LAT + 1);

    localparam logic [2:0] LOAD_IR  = 3'd0;
    localparam logic [2:0] LOAD_ACC = 3'd1;

    localparam logic [OPCODE_W-1:0] OP_NOP    = OPCODE_W'(8'h00);
    localparam logic [OPCODE_W-1:0] OP_LOAD   = OPCODE_W'(8'h01);
    localparam logic [OPCODE_W-1:0] OP_STORE  = OPCODE_W'(8'h02);
    localparam logic [OPCODE_W-1:0] OP_JMP    = OPCODE_W'(8'h03);
    localparam logic [OPCODE_W-1:0] OP_JZ     = OPCODE_W'(8'h04);
    localparam logic [OPCODE_W-1:0] OP_ALU_LO = OPCODE_W'(8'h08);
    localparam logic [OPCODE_W-1:0] OP_ALU_HI = OPCODE_W'(8'h0F);
    localparam logic [OPCODE_W-1:0] OP_HALT   = OPCODE_W'(8'h1F);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_LOAD, S_WAIT_IR, S_DECODE, S_MEM, S_LDACC, S_EXEC, S_HALT
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_W-1:0]     pc_q, pc_d;
    logic [OPCODE_W-1:0]   op_q, op_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic                  fault_q, fault_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            op_q    <= '0;
            addr_q  <= '0;
            fault_q <= 1'b0;
            tmo_q   <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            fault_q <= fault_d;
            tmo_q   <= tmo_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        op_d        = op_q;
        addr_d      = addr_q;
        fault_d     = fault_q;
        tmo_d       = '0;
        wait_d      = '0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        load_reg    = 1'b0;
        load_select = LOAD_IR;
        alu_en      = 1'b0;
        alu_op      = '0;

        case (state_q)
            S_IDLE: if (run) state_d = S_FETCH;
            S_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc_q;
                if (mem_ack) state_d = S_LOAD;
            end
            S_LOAD: begin
                load_reg = 1'b1;
                pc_d     = pc_q + 1'b1;
                state_d  = S_WAIT_IR;
            end
            S_WAIT_IR: begin
                if (wait_q == WAIT_W'(IR_LAT - 1)) state_d = S_DECODE;
                else                               wait_d  = wait_q + 1'b1;
            end
            S_DECODE: begin
                // Opcode and operand are captured here so later states do not depend on the IR holding them.
                op_d    = opcode;
                addr_d  = ir_addr;
                state_d = S_FETCH;
                if (opcode == OP_NOP) begin
                    state_d = S_FETCH;
                end else if (opcode == OP_LOAD || opcode == OP_STORE) begin
                    state_d = S_MEM;
                end else if (opcode == OP_JMP) begin
                    pc_d = ir_addr;
                end else if (opcode == OP_JZ) begin
                    if (acc_zero) pc_d = ir_addr;
                end else if (opcode >= OP_ALU_LO && opcode <= OP_ALU_HI) begin
                    state_d = S_EXEC;
                end else if (opcode == OP_HALT) begin
                    state_d = S_HALT;
                end else begin
                    fault_d = 1'b1;
                    state_d = S_HALT;
                end
            end
            S_MEM: begin
                mem_req  = 1'b1;
                mem_addr = addr_q;
                mem_we   = (op_q == OP_STORE);
                if (mem_ack) state_d = (op_q == OP_LOAD) ? S_LDACC : S_FETCH;
            end
            S_LDACC: begin
                load_reg    = 1'b1;
                load_select = LOAD_ACC;
                state_d     = S_FETCH;
            end
            S_EXEC: begin
                alu_en  = 1'b1;
                alu_op  = op_q;
                state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase

        // Shared watchdog for both request states; an ack on the last allowed cycle still wins.
        if (mem_req && !mem_ack) begin
            if (tmo_q == TMO_W'(MEM_TIMEOUT - 1)) begin
                fault_d = 1'b1;
                state_d = S_HALT;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    assign pc     = pc_q;
    assign halted = (state_q == S_HALT);
    assign fault  = fault_q;

endmodule
